fabric_config_loader: RTL and testbench

//   Configuration controller for the logic-tile / switch-box fabric.
//   - Receives a serial bitstream through a valid/ready handshake.
//   - Assembles one configuration word per target: a logic_tile mem image or a

---
 rtl/fabric_config_loader.sv | 148 ++++++++++++++
 tb/tb_fabric_config_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fabric_config_loader.sv
// fabric_config_loader: serial bitstream loader for the logic-tile / switch-box fabric.
// Words arrive LSB first over a valid/ready handshake. One registered write strobe is
// issued per completed tile or switch word. A trailing 8-bit ones-count checksum
// decides whether the fabric is enabled.
module fabric_config_loader #(
   parameter int NUM_TILES  = 8,
   parameter int NUM_SWITCH = 4,
   parameter int TILE_BITS  = 33,
   parameter int SW_BITS    = 16,
   parameter int ADDR_W     = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 cfg_bit,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   output logic                 wr_en,
   output logic                 wr_is_switch,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [TILE_BITS-1:0] wr_data,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic                 fabric_en
);

   // Bit counter and shift register must also cover the 8-bit checksum word.
   localparam int CNT_MAX = (TILE_BITS > 8) ? TILE_BITS : 8;
   localparam int CNT_W   = $clog2(CNT_MAX);

   typedef enum logic [2:0] {S_IDLE, S_TILE, S_SWITCH, S_CHECK, S_DONE, S_ERR} state_t;

   state_t               state, state_next;
   logic [CNT_W-1:0]     bit_cnt;
   logic [ADDR_W-1:0]    word_cnt;
   logic [CNT_MAX-1:0]   shift;
   logic [CNT_MAX-1:0]   word_next;
   logic [7:0]           ones_count;
   logic                 accept, start_ok, word_end, group_end;

   assign accept   = cfg_valid & cfg_ready;
   assign start_ok = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

   // Word assembled so far with the incoming bit dropped into its slot.
   always_comb begin
      // NOTE: every comb-assigned signal gets a default first so no latch is inferred.
      word_next          = shift;
      word_next[bit_cnt] = cfg_bit;
   end

   // Last-bit-of-word and last-word-of-group flags for the current phase.
   always_comb begin
      word_end  = 1'b0;
      group_end = 1'b0;
      case (state)
         S_TILE: begin
            word_end  = (bit_cnt == CNT_W'(TILE_BITS - 1));
            group_end = (word_cnt == ADDR_W'(NUM_TILES - 1));
         end
         S_SWITCH: begin
            word_end  = (bit_cnt == CNT_W'(SW_BITS - 1));
            group_end = (word_cnt == ADDR_W'(NUM_SWITCH - 1));
         end
         S_CHECK: begin
            word_end  = (bit_cnt == CNT_W'(7));
            group_end = 1'b1;
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE, S_ERR:
            if (start) state_next = S_TILE;
         S_TILE:
            if (accept && word_end && group_end)
               state_next = (NUM_SWITCH == 0) ? S_CHECK : S_SWITCH;
         S_SWITCH:
            if (accept && word_end && group_end) state_next = S_CHECK;
         S_CHECK:
            if (accept && word_end)
               state_next = (word_next[7:0] == ones_count) ? S_DONE : S_ERR;
         default:
            state_next = S_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      cfg_ready = (state == S_TILE) | (state == S_SWITCH) | (state == S_CHECK);
      busy      = cfg_ready;
      done      = (state == S_DONE);
      error     = (state == S_ERR);
      fabric_en = (state == S_DONE);
   end

   // Datapath: bit assembly, word/bit counters, ones count and registered write port.
   always_ff @(posedge clock) begin
      // NOTE: the whole datapath is reset so a mid-load reset leaves no stale word or write.
      if (reset) begin
         bit_cnt      <= '0;
         word_cnt     <= '0;
         shift        <= '0;
         ones_count   <= '0;
         wr_en        <= 1'b0;
         wr_is_switch <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
      end else begin
         wr_en <= 1'b0;
         if (start_ok) begin
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shift      <= '0;
            ones_count <= '0;
         end else if (accept) begin
            if (state != S_CHECK && cfg_bit) ones_count <= ones_count + 8'd1;
            if (word_end) begin
               bit_cnt  <= '0;
               shift    <= '0;
               word_cnt <= group_end ? '0 : word_cnt + ADDR_W'(1);
               if (state != S_CHECK) begin
                  wr_en        <= 1'b1;
                  wr_addr      <= word_cnt;
                  wr_is_switch <= (state == S_SWITCH);
                  wr_data      <= (state == S_SWITCH) ? TILE_BITS'(word_next[SW_BITS-1:0])
                                                      : word_next[TILE_BITS-1:0];
               end
            end else begin
               bit_cnt <= bit_cnt + CNT_W'(1);
               shift   <= word_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: decoder image, bad checksum, valid gaps,
// mid-load reset, ignored start, all-ones wrap.
module tb_fabric_config_loader;

   logic        clock = 1'b0;
   logic        reset, start, cfg_bit, cfg_valid;
   logic        cfg_ready, wr_en, wr_is_switch;
   logic [3:0]  wr_addr;
   logic [32:0] wr_data;
   logic        busy, done, error, fabric_en;

   int errors = 0;
   int checks = 0;

   logic [37:0] wq[$];

   fabric_config_loader dut (
      .clock(clock), .reset(reset), .start(start), .cfg_bit(cfg_bit),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .wr_en(wr_en),
      .wr_is_switch(wr_is_switch), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .error(error), .fabric_en(fabric_en)
   );

   always #5 clock = ~clock;

   // Record every write strobe as {is_switch, addr, data}.
   always @(negedge clock) if (wr_en) wq.push_back({wr_is_switch, wr_addr, wr_data});

   initial begin
      #5ms;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one bit after 'gap' idle cycles; returns at the negedge after acceptance.
   task automatic send_bit(input logic b, input int gap, input logic st);
      int n;
      if (gap > 0) begin
         cfg_valid = 1'b0;
         repeat (gap) @(negedge clock);
      end
      cfg_valid = 1'b1;
      cfg_bit   = b;
      start     = st;
      n = 0;
      while (!cfg_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (n >= 20) check("ready_timeout", {63'd0, cfg_ready}, 64'd1);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Full stream: 8 tiles, 4 switches, checksum. Optional start pulse on first switch bit.
   task automatic send_stream(input logic ones, input logic [7:0] chk, input int maxgap,
                              input logic pulse_in_switch);
      logic [32:0] tw;
      logic [15:0] sw;
      for (int t = 0; t < 8; t++) begin
         tw = ones ? {33{1'b1}} : (33'h1 << t);
         for (int i = 0; i < 33; i++) send_bit(tw[i], $urandom_range(maxgap, 0), 1'b0);
      end
      sw = ones ? 16'hFFFF : 16'h0001;
      for (int s = 0; s < 4; s++)
         for (int i = 0; i < 16; i++)
            send_bit(sw[i], $urandom_range(maxgap, 0), pulse_in_switch && s == 0 && i == 0);
      for (int i = 0; i < 8; i++) send_bit(chk[i], $urandom_range(maxgap, 0), 1'b0);
      cfg_valid = 1'b0;
   endtask

   task automatic check_writes(input string tag, input logic ones);
      logic [37:0] exp;
      check({tag, "_count"}, 64'(wq.size()), 64'd12);
      for (int k = 0; k < 12 && k < wq.size(); k++) begin
         if (k < 8) exp = {1'b0, 4'(k), ones ? {33{1'b1}} : (33'h1 << k)};
         else       exp = {1'b1, 4'(k - 8), 17'd0, ones ? 16'hFFFF : 16'h0001};
         check($sformatf("%s_wr%0d", tag, k), 64'(wq[k]), 64'(exp));
      end
   endtask

   task automatic check_status(input string tag, input logic b, input logic d,
                               input logic e, input logic f);
      check({tag, "_busy"},  {63'd0, busy},      {63'd0, b});
      check({tag, "_done"},  {63'd0, done},      {63'd0, d});
      check({tag, "_error"}, {63'd0, error},     {63'd0, e});
      check({tag, "_fen"},   {63'd0, fabric_en}, {63'd0, f});
   endtask

   task automatic check_all_zero(input string tag);
      check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
      check({tag, "_ready"}, {63'd0, cfg_ready}, 64'd0);
      check({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
      check({tag, "_wr_sw"}, {63'd0, wr_is_switch}, 64'd0);
      check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
      check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_all_zero("reset");

      // Test 1: decoder image, good checksum.
      wq.delete();
      do_start();
      check_status("t1_start", 1'b1, 1'b0, 1'b0, 1'b0);
      send_stream(1'b0, 8'h0C, 0, 1'b0);
      check_writes("t1", 1'b0);
      check_status("t1_end", 1'b0, 1'b1, 1'b0, 1'b1);
      check("t1_hold_addr", 64'(wr_addr), 64'd3);
      check("t1_hold_data", 64'(wr_data), 64'd1);
      check("t1_hold_sw", {63'd0, wr_is_switch}, 64'd1);

      // Test 2: bad checksum.
      wq.delete();
      do_start();
      send_stream(1'b0, 8'h0D, 0, 1'b0);
      check_writes("t2", 1'b0);
      check_status("t2_end", 1'b0, 1'b0, 1'b1, 1'b0);

      // Test 3: random valid gaps.
      wq.delete();
      do_start();
      send_stream(1'b0, 8'h0C, 5, 1'b0);
      check_writes("t3", 1'b0);
      check_status("t3_end", 1'b0, 1'b1, 1'b0, 1'b1);

      // Test 4: reset at tile 3 after 17 bits.
      wq.delete();
      do_start();
      for (int t = 0; t < 3; t++)
         for (int i = 0; i < 33; i++) send_bit((i == t), 0, 1'b0);
      for (int i = 0; i < 17; i++) send_bit(1'b0, 0, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      cfg_valid = 1'b0;
      check_all_zero("t4_rst");
      repeat (3) @(negedge clock);
      check("t4_writes", 64'(wq.size()), 64'd3);
      wq.delete();
      do_start();
      send_stream(1'b0, 8'h0C, 0, 1'b0);
      check_writes("t4_reload", 1'b0);
      check_status("t4_end", 1'b0, 1'b1, 1'b0, 1'b1);

      // Test 5: start during SWITCH is ignored; start in DONE restarts.
      wq.delete();
      do_start();
      send_stream(1'b0, 8'h0C, 0, 1'b1);
      check_writes("t5", 1'b0);
      check_status("t5_end", 1'b0, 1'b1, 1'b0, 1'b1);
      wq.delete();
      @(negedge clock);
      start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
      @(negedge clock);
      start = 1'b0; cfg_valid = 1'b0;
      check_status("t5_restart", 1'b1, 1'b0, 1'b0, 1'b0);

      // Test 6: all-ones payload; an extra accepted bit on the start cycle would break 8'h48.
      send_stream(1'b1, 8'h48, 0, 1'b0);
      check_writes("t6", 1'b1);
      check_status("t6_end", 1'b0, 1'b1, 1'b0, 1'b1);
      wq.delete();
      do_start();
      send_stream(1'b1, 8'hFF, 0, 1'b0);
      check("t6b_writes", 64'(wq.size()), 64'd12);
      check_status("t6b_end", 1'b0, 1'b0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
